// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and defaults for the round-robin mux arbiter: FSM encoding,
// default parameters and the 2-bit requester index.
package rr_mux_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_BURST_LEN = 4;

  typedef logic [1:0] idx_t;

  function automatic logic [3:0] onehot4(idx_t idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Bundle of requester inputs and the arbitrated output port of rr_mux_arbiter.
interface rr_mux_arbiter_if #(
  parameter int WIDTH = rr_mux_arbiter_pkg::DEF_WIDTH
);
  import rr_mux_arbiter_pkg::*;

  // Output handshake: a beat moves when out_valid && out_ready at a rising
  // clk edge; while out_valid=1 and out_ready=0, y/sel/grant hold stable and
  // the beat is never withdrawn.
  logic [3:0]       req;
  logic [WIDTH-1:0] w0;
  logic [WIDTH-1:0] w1;
  logic [WIDTH-1:0] w2;
  logic [WIDTH-1:0] w3;
  logic             out_ready;
  idx_t             sel;
  logic [3:0]       grant;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  arb_state_e       dbg_state;

  modport master (
    output req, w0, w1, w2, w3, out_ready,
    input  sel, grant, y, out_valid, dbg_state
  );

  modport slave (
    input  req, w0, w1, w2, w3, out_ready,
    output sel, grant, y, out_valid, dbg_state
  );

endinterface

// File: rtl/rr_mux4.sv
// Plain 4-to-1 multiplexer, WIDTH bits per leg.
module rr_mux4 #(
  parameter int WIDTH = 4
) (
  input  logic [1:0]       sel_i,
  input  logic [WIDTH-1:0] d0_i,
  input  logic [WIDTH-1:0] d1_i,
  input  logic [WIDTH-1:0] d2_i,
  input  logic [WIDTH-1:0] d3_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = d0_i;
    case (sel_i)
      2'd0:    y_o = d0_i;
      2'd1:    y_o = d1_i;
      2'd2:    y_o = d2_i;
      default: y_o = d3_i;
    endcase
  end

endmodule

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first requester at or after ptr_i (mod 4).
module rr_priority_pick
  import rr_mux_arbiter_pkg::*;
(
  input  logic [3:0] req_i,
  input  idx_t       ptr_i,
  output idx_t       winner_o,
  output logic       any_req_o
);

  logic found;
  idx_t idx;

  always_comb begin
    winner_o  = '0;
    found     = 1'b0;
    idx       = '0;
    any_req_o = |req_i;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_i + 2'(k);
      if (!found && req_i[idx]) begin
        winner_o = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters; the grantee
// keeps the port for up to BURST_LEN accepted beats, then the grant rotates.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic            clk,
  input  logic            rst,
  rr_mux_arbiter_if.slave bus
);

  localparam logic [3:0] BL = 4'(BURST_LEN);

  arb_state_e       state_q, state_d;
  idx_t             ptr_q, ptr_d;
  idx_t             sel_q, sel_d;
  logic [3:0]       grant_q, grant_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             valid_q, valid_d;
  logic [3:0]       cnt_q, cnt_d;

  idx_t             winner;
  logic             any_req;
  idx_t             mux_sel;
  logic [WIDTH-1:0] mux_y;

  rr_priority_pick u_pick (
    .req_i     (bus.req),
    .ptr_i     (ptr_q),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  // While idle the mux already points at the upcoming winner so its word can
  // be captured on the same edge the grant starts.
  assign mux_sel = (state_q == IDLE) ? winner : sel_q;

  rr_mux4 #(.WIDTH(WIDTH)) u_mux (
    .sel_i (mux_sel),
    .d0_i  (bus.w0),
    .d1_i  (bus.w1),
    .d2_i  (bus.w2),
    .d3_i  (bus.w3),
    .y_o   (mux_y)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    y_d     = y_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = BURST;
          sel_d   = winner;
          grant_d = onehot4(winner);
          y_d     = mux_y;
          valid_d = 1'b1;
          cnt_d   = 4'd1;
        end
      end
      BURST: begin
        if (bus.out_ready) begin
          if (bus.req[sel_q] && (cnt_q < BL)) begin
            y_d   = mux_y;
            cnt_d = cnt_q + 4'd1;
          end else begin
            // Served index drops to lowest priority for the next pick.
            state_d = IDLE;
            valid_d = 1'b0;
            grant_d = '0;
            ptr_d   = sel_q + 2'd1;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.grant     = grant_q;
  assign bus.y         = y_q;
  assign bus.out_valid = valid_q;
  assign bus.dbg_state = state_q;

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one 4-to-1, WIDTH-bit multiplexer datapath among four requesters.
- Selects a requester, drives the mux select and presents the selected word on a registered valid/ready output port.
- A grant is held for a burst of up to BURST_LEN accepted beats, then rotates.
- Sits between four producer blocks and a single downstream consumer; the mux select it generates (sel) is exported for debug and for any external mux instance.

Parameters:
- WIDTH, 4, data word width per requester and of the output.
- BURST_LEN, 4, maximum accepted beats per grant (legal range 1..15).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request per requester; req[i] belongs to data input wi.
- w0  input  WIDTH  data of requester 0.
- w1  input  WIDTH  data of requester 1.
- w2  input  WIDTH  data of requester 2.
- w3  input  WIDTH  data of requester 3.
- out_ready  input  1  downstream accepts y this cycle when out_valid=1.
- sel  output  2  index of the current grantee (mux select).
- grant  output  4  one-hot grant; all zero when idle.
- y  output  WIDTH  registered output word.
- out_valid  output  1  y holds an unaccepted beat.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, grant=0, sel=0, y=0, out_valid=0, beat_cnt=0, priority pointer ptr=0. Synchronous only; rst dominates all other inputs, including mid-burst.
- State IDLE:
  - If req==0: remain in IDLE.
  - Else: winner = first i with req[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Next cycle: grant=onehot(winner), sel=winner, y=w[winner] (sampled this cycle), out_valid=1, beat_cnt=1, go to BURST.
  - Latency from req rising to out_valid: 1 cycle.
- State BURST (out_valid=1):
  - If out_ready=0: y, sel, grant and out_valid hold stable. A beat is never retracted, even if req[sel] drops.
  - If out_ready=1 (beat accepted) and req[sel]=1 and beat_cnt<BURST_LEN: next cycle y=w[sel] sampled now, out_valid stays 1, beat_cnt+1. This gives back-to-back beats with no bubble.
  - Otherwise, on acceptance, the burst ends: next cycle out_valid=0, grant=0, ptr=sel+1 mod 4 (wrap 3→0), beat_cnt=0, go to IDLE. This leaves one mandatory idle cycle between grants.
- sel and grant change only on the cycle a new grant starts or the burst ends; never mid-burst.
- No requester starves: after any burst the just-served index has lowest priority, so any waiting requester is served within 3 bursts.
- Simultaneous events:
  - req changes during BURST affect only the continue/end decision at acceptance.
  - rst during BURST drops the beat (out_valid=0 next cycle).

Decomposition:
- Shared package/include holds:
  - State encodings IDLE=1'b0, BURST=1'b1.
  - Default WIDTH=4, BURST_LEN=4.
  - A 2-bit index type for sel/ptr.
- One natural sub-module: rr_priority_pick. It is purely combinational: inputs req[3:0] and ptr[1:0]; outputs winner[1:0] and any_req.
- The data mux itself is the team's existing 4x4 multiplexer; instantiate it with sel driving its select and w0..w3 as its inputs, then register its output into y.

Test Plan:
- Reset: assert rst for 2 cycles with req=4'b1111 → grant=0, sel=0, y=0, out_valid=0 throughout; first grant after release goes to requester 0.
- Single requester burst:
  - Stimulus: req=4'b0100, w2=4'hA,4'hB,4'hC,4'hD on successive cycles, out_ready=1 constantly.
  - Response: out_valid 1 cycle after req; 4 beats y=A..D on consecutive cycles with sel=2, grant=4'b0100; then out_valid=0 one cycle; then a new burst starts.
- Rotation: req=4'b1111 held, out_ready=1, BURST_LEN=1 → sel sequence 0,1,2,3,0 with one idle cycle between each grant.
- Backpressure: during a burst hold out_ready=0 for 5 cycles and change w1 each cycle → y, sel and grant are frozen; the beat value equals the original sample; it is accepted on the first out_ready=1.
- Early drop: requester 3 deasserts req after 2 accepted beats → burst ends after the beat in flight is accepted; next grant wraps to requester 0 if it is requesting.
- Mid-burst reset: pulse rst while out_valid=1, out_ready=0 → next cycle all outputs at reset values; ptr=0.
